// File: rtl/seq_detect_scheduler_pkg.sv
// seq_detect_sched_pkg: shared FSM state type and width helpers for the sequence-detector scheduler.
package seq_detect_sched_pkg;
   typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
   function automatic int cnt_w(int word_w);
      return $clog2(word_w + 1);
   endfunction
   function automatic int id_w(int nreq);
      return nreq > 1 ? $clog2(nreq) : 1;
   endfunction
endpackage

// File: rtl/seq_detect_scheduler_if.sv
// seq_detect_scheduler_if: requester-side bundle (request, word, grant and result) of the scheduler.
interface seq_detect_scheduler_if
   import seq_detect_sched_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WORD_W = 8
);
   logic [NREQ-1:0]            req;
   logic [NREQ*WORD_W-1:0]     data;
   logic [NREQ-1:0]            grant;
   logic                       done;
   logic [id_w(NREQ)-1:0]      done_id;
   logic [cnt_w(WORD_W)-1:0]   match_cnt;
   modport master (output req, data, input grant, done, done_id, match_cnt);
   modport slave  (input req, data, output grant, done, done_id, match_cnt);
endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pointer and one-hot winner select; the pointer moves past the winner on update.
module rr_arbiter
   import seq_detect_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic                   update,
   output logic [NREQ-1:0]        win_oh,
   output logic [id_w(NREQ)-1:0]  win_idx
);
   localparam int IW = id_w(NREQ);
   logic [IW-1:0] ptr, j;
   // scan from lowest to highest priority so the highest-priority requester overwrites last
   always_comb begin
      win_oh = '0;
      win_idx = '0;
      j = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % NREQ);
         if (req[j]) begin
            win_oh = NREQ'(1) << j;
            win_idx = j;
         end
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= '0;
      else if (update) ptr <= win_idx == IW'(NREQ - 1) ? '0 : win_idx + 1'b1;
endmodule

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: shares one serial detector among requesters, shifting each word MSB-first and counting hits.
// Define SEQ_DET_MEALY_EN for a Mealy detector (no DRAIN cycle); default assumes a Moore detector.
module seq_detect_scheduler
   import seq_detect_sched_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WORD_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_detect_scheduler_if.slave bus,
   output logic                  det_w,
   input  logic                  det_z,
   output logic                  det_reset
);
   localparam int CW = cnt_w(WORD_W);
   localparam int IW = id_w(NREQ);
   state_t state, state_n;
   logic [WORD_W-1:0] sh, sh_n;
   logic [CW-1:0] idx, hits, hits_n;
   logic [IW-1:0] id, win_idx;
   logic [NREQ-1:0] win_oh;
   logic accept, last, cnt_en;
   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk(clk),
      .reset(reset),
      .req(bus.req),
      .update(accept),
      .win_oh(win_oh),
      .win_idx(win_idx)
   );
`ifdef SEQ_DET_MEALY_EN
   localparam state_t AFTER_SHIFT = DONE;
   assign cnt_en = state == SHIFT;
`else
   // a Moore detector answers one cycle late: skip index 0, take the DRAIN cycle instead
   localparam state_t AFTER_SHIFT = DRAIN;
   assign cnt_en = (state == SHIFT && idx != '0) || state == DRAIN;
`endif
   assign accept = state == IDLE && |bus.req;
   assign last = idx == CW'(WORD_W - 1);
   assign hits_n = (cnt_en && det_z && hits != CW'(WORD_W)) ? hits + 1'b1 : hits;
   assign sh_n = state == SHIFT ? sh << 1 : sh;
   always_comb begin
      state_n = IDLE;
      state_n = state == IDLE  ? (accept ? CLR : IDLE) :
                state == CLR   ? SHIFT :
                state == SHIFT ? (last ? AFTER_SHIFT : SHIFT) :
                state == DRAIN ? DONE : IDLE;
   end
   // outputs are registered from next-state values so they line up with the state they belong to
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         sh <= '0;
         idx <= '0;
         hits <= '0;
         id <= '0;
         bus.grant <= '0;
         bus.done <= 1'b0;
         bus.done_id <= '0;
         bus.match_cnt <= '0;
         det_w <= 1'b0;
         det_reset <= 1'b1;
      end else begin
         state <= state_n;
         sh <= accept ? bus.data[int'(win_idx) * WORD_W +: WORD_W] : sh_n;
         id <= accept ? win_idx : id;
         hits <= accept ? '0 : hits_n;
         idx <= state == SHIFT ? idx + 1'b1 : '0;
         bus.grant <= accept ? win_oh : '0;
         bus.done <= state_n == DONE;
         det_w <= state_n == SHIFT && sh_n[WORD_W-1];
         det_reset <= !(state_n inside {SHIFT, DRAIN});
         if (state_n == DONE) begin
            bus.done_id <= id;
            bus.match_cnt <= hits_n;
         end
      end
endmodule
